// File: rtl/writeback_unit_if.sv
// Writeback handshake bundle: ALU/load result offers in,
// register-file write port and queue status out.
interface writeback_unit_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [63:0]   alu_data;
  logic          alu_ready;

  logic          ld_valid;
  logic [4:0]    ld_rd;
  logic [63:0]   ld_data;
  logic          ld_ready;

  logic          WriteReg;
  logic [4:0]    RegWrite;
  logic [63:0]   WriteData;
  logic [31:0]   pending;
  logic [CW-1:0] count;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    input  WriteReg, RegWrite, WriteData,
    input  pending, count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    output WriteReg, RegWrite, WriteData,
    output pending, count
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback result queue: merges ALU and load results in
// program order and drains one register write per cycle.
module writeback_unit #(
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  writeback_unit_if.slave wb
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } entry_t;

  entry_t        q [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [4:0]    idx_q;
  logic [63:0]   dat_q;

  logic          ld_go;
  logic          alu_go;
  logic          pop;
  logic [AW-1:0] alu_slot;
  logic [1:0]    npush;
  logic [AW-1:0] off;
  logic [31:0]   pend;

  assign wb.ld_ready  = cnt < CW'(DEPTH);
  assign wb.alu_ready = (cnt <= CW'(DEPTH - 2)) ||
                        (cnt == CW'(DEPTH - 1) && !wb.ld_valid);

  // x0 results complete the handshake but never occupy a slot
  assign ld_go  = reset && wb.ld_valid && wb.ld_ready &&
                  (wb.ld_rd != 5'd0);
  assign alu_go = reset && wb.alu_valid && wb.alu_ready &&
                  (wb.alu_rd != 5'd0);
  assign pop    = cnt != '0;

  assign alu_slot = ld_go ? tail + AW'(1) : tail;
  assign npush    = {1'b0, ld_go} + {1'b0, alu_go};

  always_ff @(posedge clk) begin
    if (ld_go)
      q[tail] <= '{rd: wb.ld_rd, data: wb.ld_data};
    if (alu_go)
      q[alu_slot] <= '{rd: wb.alu_rd, data: wb.alu_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      we_q  <= 1'b0;
      idx_q <= 5'd0;
      dat_q <= 64'd0;
    end else begin
      tail <= tail + AW'(npush);
      cnt  <= cnt + CW'(npush) - CW'(pop);
      if (pop) begin
        head  <= head + AW'(1);
        we_q  <= 1'b1;
        idx_q <= q[head].rd;
        dat_q <= q[head].data;
      end else begin
        we_q <= 1'b0;
      end
    end
  end

  // Live slots are those within cnt of head, modulo DEPTH
  always_comb begin
    pend = '0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - head;
      if (CW'(off) < cnt)
        pend[q[i].rd] = 1'b1;
    end
    if (we_q)
      pend[idx_q] = 1'b1;
  end

  assign wb.pending   = pend;
  assign wb.count     = cnt;
  assign wb.WriteReg  = we_q;
  assign wb.RegWrite  = idx_q;
  assign wb.WriteData = dat_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed offers,
// expected writes queued, monitor checks every write.
module tb_writeback_unit;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  writeback_unit_if #(.DEPTH(DEPTH)) wb ();

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .wb   (wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;

  wr_t         sb[$];
  int          nc = 0;
  int          nf = 0;
  int          mcnt = 0;
  logic [63:0] rf [32];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nc++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every register write must match the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (reset && wb.WriteReg) begin
        chk("rd_nonzero", {63'd0, wb.RegWrite != 5'd0}, 64'd1);
        if (sb.size() == 0) begin
          nc++;
          nf++;
          $display("FAIL unexpected_write: got rd %0d data %0h expected none",
                   wb.RegWrite, wb.WriteData);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_rd", {59'd0, wb.RegWrite}, {59'd0, e.rd});
          chk("wr_data", wb.WriteData, e.data);
          rf[wb.RegWrite] = wb.WriteData;
        end
      end
    end
  end

  // One cycle of offers; entered and left at 1 time unit after posedge
  task automatic cyc(input logic lv, input logic [4:0] lrd,
                     input logic [63:0] ldd,
                     input logic av, input logic [4:0] ard,
                     input logic [63:0] ad,
                     output logic lacc, output logic aacc);
    logic elr;
    logic ear;
    int   np;
    wb.ld_valid  = lv;
    wb.ld_rd     = lrd;
    wb.ld_data   = ldd;
    wb.alu_valid = av;
    wb.alu_rd    = ard;
    wb.alu_data  = ad;
    @(negedge clk);
    elr = mcnt < DEPTH;
    ear = (mcnt <= DEPTH - 2) || (mcnt == DEPTH - 1 && !lv);
    chk("count", 64'(wb.count), 64'(mcnt));
    chk("ld_ready", {63'd0, wb.ld_ready}, {63'd0, elr});
    chk("alu_ready", {63'd0, wb.alu_ready}, {63'd0, ear});
    lacc = lv && elr;
    aacc = av && ear;
    np = 0;
    if (lacc && lrd != 5'd0) begin
      sb.push_back('{lrd, ldd});
      np++;
    end
    if (aacc && ard != 5'd0) begin
      sb.push_back('{ard, ad});
      np++;
    end
    mcnt = mcnt + np - ((mcnt != 0) ? 1 : 0);
    @(posedge clk);
    #1;
    wb.ld_valid  = 1'b0;
    wb.alu_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic a;
    logic b;
    repeat (n) cyc(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, a, b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic a;
    logic b;
    for (int i = 0; i < 32; i++) rf[i] = 64'd0;

    // Offers held high during reset must not transfer
    wb.ld_valid  = 1'b1;
    wb.ld_rd     = 5'd3;
    wb.ld_data   = 64'h33;
    wb.alu_valid = 1'b1;
    wb.alu_rd    = 5'd4;
    wb.alu_data  = 64'h44;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", {63'd0, wb.WriteReg}, 64'd0);
    chk("rst_idx", {59'd0, wb.RegWrite}, 64'd0);
    chk("rst_data", wb.WriteData, 64'd0);
    chk("rst_count", 64'(wb.count), 64'd0);
    chk("rst_pending", {32'd0, wb.pending}, 64'd0);
    chk("rst_ld_ready", {63'd0, wb.ld_ready}, 64'd1);
    chk("rst_alu_ready", {63'd0, wb.alu_ready}, 64'd1);
    wb.ld_valid  = 1'b0;
    wb.alu_valid = 1'b0;
    reset = 1'b1;
    idle(2);
    chk("post_rst_pending", {32'd0, wb.pending}, 64'd0);

    // Single ALU result, two-edge latency
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'hABCD, a, b);
    chk("t1_pend_e0", {63'd0, wb.pending[5]}, 64'd1);
    chk("t1_we_e0", {63'd0, wb.WriteReg}, 64'd0);
    idle(1);
    chk("t1_we_e1", {63'd0, wb.WriteReg}, 64'd1);
    chk("t1_pend_e1", {63'd0, wb.pending[5]}, 64'd1);
    idle(1);
    chk("t1_we_e2", {63'd0, wb.WriteReg}, 64'd0);
    chk("t1_pend_e2", {32'd0, wb.pending}, 64'd0);

    // Same-cycle load and ALU to one register: load first
    cyc(1'b1, 5'd7, 64'd1, 1'b1, 5'd7, 64'd2, a, b);
    idle(3);
    chk("rf7_final", rf[7], 64'd2);

    // x0 result accepted but dropped
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFFFF, a, b);
    chk("x0_acc", {63'd0, b}, 64'd1);
    chk("x0_count", 64'(wb.count), 64'd0);
    chk("x0_pending", {32'd0, wb.pending}, 64'd0);
    idle(1);
    chk("x0_we", {63'd0, wb.WriteReg}, 64'd0);

    // Fill with two offers per cycle; sources hold until accepted
    begin
      int   li;
      int   ai;
      int   guard;
      int   blocked;
      logic la;
      logic aa;
      li = 0;
      ai = 0;
      guard = 0;
      blocked = 0;
      while ((li < 5 || ai < 5) && guard < 60) begin
        cyc(li < 5, 5'(10 + li), 64'h100 + 64'(li),
            ai < 5, 5'(20 + ai), 64'h200 + 64'(ai), la, aa);
        if (li < 5 && ai < 5 && !aa) blocked++;
        if (la) li++;
        if (aa) ai++;
        guard++;
      end
      chk("full_done", {63'd0, guard < 60}, 64'd1);
      chk("full_blocked", {63'd0, blocked > 0}, 64'd1);
    end
    idle(6);
    chk("full_drain", 64'(sb.size()), 64'd0);

    // Reset asserted between edges with three entries queued
    cyc(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, a, b);
    cyc(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44, a, b);
    @(negedge clk);
    chk("mid_pending", {32'd0, wb.pending}, 64'h1E);
    chk("mid_count", 64'(wb.count), 64'd3);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_we", {63'd0, wb.WriteReg}, 64'd0);
    chk("mid_rst_count", 64'(wb.count), 64'd0);
    chk("mid_rst_pending", {32'd0, wb.pending}, 64'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mcnt = 0;
    idle(5);

    // Streaming one ALU result per cycle
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'(i), 64'(i * 3), a, b);
      chk("stream_max", {63'd0, wb.count <= 2}, 64'd1);
    end
    idle(4);
    chk("stream_drain", 64'(sb.size()), 64'd0);
    chk("rf20_final", rf[20], 64'd60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of result-queue entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  meaning the asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have ports alu_valid/alu_rd/alu_data  input  1/5/64  meaning the ALU result offer: valid, destination register, value.
REQ-005 SHALL have port alu_ready  output  1  meaning the ALU offer is accepted this cycle when alu_valid=1.
REQ-006 SHALL have ports ld_valid/ld_rd/ld_data  input  1/5/64  meaning the load-data result offer: valid, destination register, value.
REQ-007 SHALL have port ld_ready  output  1  meaning the load offer is accepted this cycle when ld_valid=1.
REQ-008 SHALL have ports WriteReg/RegWrite/WriteData  output  1/5/64  meaning the register-file write port: enable, index, data.
REQ-009 SHALL have port pending  output  32  meaning bit r=1 while any queued or output-staged write targets register r.
REQ-010 SHALL have port count  output  log2(DEPTH)+1  meaning the number of occupied queue entries.

Function
REQ-011 SHALL hold a circular FIFO of DEPTH entries {rd[4:0], data[63:0]} with head/tail pointers that wrap modulo DEPTH.
REQ-012 SHALL compute ld_ready = (count < DEPTH) from registered count only.
REQ-013 SHALL compute alu_ready = (count <= DEPTH-2) || (count == DEPTH-1 && !ld_valid).
REQ-014 SHALL make a transfer when valid && ready on a rising edge; the offer is consumed in that cycle.
REQ-015 SHALL, when both sources transfer in the same cycle, enqueue the load entry first and the ALU entry second (load has program-order priority).
REQ-016 SHALL accept a transfer whose rd = 0 but SHALL NOT enqueue it (x0 writes are discarded; count unchanged by it).
REQ-017 SHALL pop the head entry every cycle the FIFO is non-empty and load it into the WriteReg/RegWrite/WriteData output registers with WriteReg=1.
REQ-018 SHALL drive WriteReg=0 on every cycle following a cycle with an empty FIFO; RegWrite and WriteData hold their last values.
REQ-019 SHALL allow push and pop in the same cycle; count next = count + pushes - pop, never exceeding DEPTH or going below 0.
REQ-020 SHALL have latency 2 edges from transfer to write: an entry transferred at edge N into an empty FIFO appears with WriteReg=1 after edge N+1.
REQ-021 SHALL preserve order: writes to the register file occur in enqueue order, so the last-accepted value for a register wins.
REQ-022 SHALL drive pending combinationally as the OR of one-hot(rd) over all valid FIFO entries plus the output stage when WriteReg=1.
REQ-023 SHALL never emit WriteReg=1 with RegWrite=0.

Reset
REQ-024 SHALL, while reset=0, immediately clear head, tail, count to 0, WriteReg to 0, RegWrite to 0, WriteData to 64'd0.
REQ-025 SHALL drive pending=0, ld_ready=1, alu_ready=1 (DEPTH>=2) during and after reset until the first transfer.
REQ-026 SHALL discard all queued entries on reset assertion mid-operation; no write for them is emitted after reset release.
REQ-027 SHALL ignore valid inputs while reset=0 (no transfers occur).

Verification
REQ-028 Single ALU: alu_valid=1, alu_rd=5, alu_data=64'hABCD at edge 0 -> WriteReg=1, RegWrite=5, WriteData=64'hABCD after edge 1 only; pending[5]=1 between edges 0 and 2.
REQ-029 Simultaneous: ld rd=7 data=1 and alu rd=7 data=2 in one cycle -> writes (7,1) then (7,2) on consecutive cycles; final register value 2.
REQ-030 x0 drop: alu_rd=0, alu_data=64'hFFFF -> alu_ready=1, count stays 0, WriteReg stays 0, pending=0.
REQ-031 Full: DEPTH=4, hold pops by filling with 2 transfers/cycle -> at count=3 with ld_valid=1, alu_ready=0, ld_ready=1; at count=4 both ready=0; no entry lost or duplicated; pointers wrap correctly over 10 writes.
REQ-032 Reset mid-operation: 3 entries queued, reset=0 asynchronously between edges -> WriteReg=0, count=0, pending=0 immediately; after release no stale write appears.
REQ-033 Streaming: alu_valid=1 every cycle with rd=1..20 -> one write per cycle, indices 1..20 in order, count never exceeds 2.
